mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps, one step per clock. It drives the 2-bit aluop consumed by the ALU decoder, plus all datapath mux selects and write enables. Outputs are Moore outputs decoded from the current state, except pcen, which also uses the zero flag.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-if-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  6  instruction opcode from the instruction register
zero  input  1  ALU zero flag
aluop  output  2  to ALU decoder: 00 add, 01 sub, 10 use funct
alusrca  output  1  ALU A: 0 PC, 1 register A
alusrcb  output  2  ALU B: 00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
iord  output  1  memory address: 0 PC, 1 ALUOut
irwrite  output  1  instruction register write enable
memwrite  output  1  data memory write enable
regwrite  output  1  register file write enable
regdst  output  1  write register: 0 rt, 1 rd
memtoreg  output  1  writeback data: 0 ALUOut, 1 memory data
pcen  output  1  PC write enable = pcwrite | (branch & zero)
state  output  4  current state encoding, for debug

Behaviour:
- State register: 4 bits, updated on rising clk. If reset=1 at an edge, state becomes FETCH(0), regardless of the current state or op. Reset takes priority over every transition.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12-15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR (lw, sw), EXECUTE (rtype), BRANCH (beq), ADDIEX (addi), JUMP (j). Any other op -> FETCH; it is a no-op and the PC has already advanced by 4.
  - MEMADR -> MEMRD (lw) or MEMWR (sw). op is re-sampled here; the IR is stable because irwrite=0. Any other op -> FETCH.
  - MEMRD -> MEMWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - EXECUTE -> ALUWB.
  - ADDIEX -> ADDIWB.
- Outputs per state (unlisted outputs = 0; aluop, alusrcb and pcsrc default to 00):
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Internal signals: pcwrite and branch are not ports.
- pcen is combinational and responds to zero in the same cycle. In every state except FETCH, JUMP and BRANCH-with-zero=1, pcen=0.
- Cycle counts per instruction, from FETCH to return to FETCH: lw 5, sw 4, rtype 4, addi 4, beq 3, j 3, undefined op 2.
- After reset: state=0 and outputs equal the FETCH decode, so pcen=1 and irwrite=1 in the first cycle after reset is released.
- Reset mid-instruction: any in-progress write enable drops on the edge that applies reset. No regwrite or memwrite is issued after that edge.

Test Plan:
- Reset held for 2 cycles while in EXECUTE -> state=0 on the first reset edge; irwrite=1, pcen=1, aluop=00, alusrcb=01.
- op=100011 (lw) -> states 0,1,2,3,4,0. memtoreg=1 and regwrite=1 only in state 4; iord=1 only in state 3.
- op=101011 (sw) -> states 0,1,2,5,0. memwrite=1 for exactly one cycle with iord=1; regwrite never asserts.
- op=000000 (rtype) -> states 0,1,6,7,0. aluop=10 in state 6; regdst=1 and regwrite=1 in state 7.
- op=000100 (beq): zero=1 -> pcen=1 and pcsrc=01 in state 8. Repeat with zero=0 -> pcen=0 in state 8. Both runs return to state 0 after 3 cycles.
- op=000010 (j) -> states 0,1,11,0 with pcsrc=10 and pcen=1 in state 11. op=111111 -> states 0,1,0 with no write enables in state 1. op=001000 (addi) -> states 0,1,9,10,0 with regwrite=1 and regdst=0 in state 10.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Latency: one state per clock; lw 5, sw/rtype/addi 4, beq/j 3, undefined op 2 cycles FETCH-to-FETCH.
// Backpressure: none; the FSM advances every cycle and only pcen depends combinationally on zero.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   pcwrite;
  logic   branch;

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  // Next-state selection; unknown opcodes and illegal encodings fall back to FETCH.
  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH:   nxt_state = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) nxt_state = MEMADR;
        else if (op == OP_RTYPE)        nxt_state = EXECUTE;
        else if (op == OP_BEQ)          nxt_state = BRANCH;
        else if (op == OP_ADDI)         nxt_state = ADDIEX;
        else if (op == OP_J)            nxt_state = JUMP;
        else                            nxt_state = FETCH;
      end
      // IR is held (irwrite=0) so op is still the decoded instruction here.
      MEMADR: begin
        if (op == OP_LW)      nxt_state = MEMRD;
        else if (op == OP_SW) nxt_state = MEMWR;
        else                  nxt_state = FETCH;
      end
      MEMRD:   nxt_state = MEMWB;
      EXECUTE: nxt_state = ALUWB;
      ADDIEX:  nxt_state = ADDIWB;
      default: nxt_state = FETCH;
    endcase
  end

  // Moore output decode of the current state.
  always_comb begin
    aluop    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (cur_state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch resolution uses the live zero flag in the BRANCH cycle.
  assign pcen  = pcwrite | (branch & zero);
  assign state = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against an instruction-level reference model.
// Latency: samples every cycle on the falling edge, one comparison pair per state visited.
// Backpressure: not applicable; zero is randomized each cycle and reset injected at random steps.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       pcen;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  logic [13:0] outs;

  mips_multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .aluop    (aluop),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .iord     (iord),
    .irwrite  (irwrite),
    .memwrite (memwrite),
    .regwrite (regwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .pcen     (pcen),
    .state    (state)
  );

  always #5 clk = ~clk;

  assign outs = {aluop, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
                 regwrite, regdst, memtoreg, pcen};

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected control word for a step, straight from the per-step control table.
  function automatic logic [13:0] model_out(input int s, input logic z);
    logic [1:0] a_op, srcb, psrc;
    logic srca, ad, irw, mw, rw, rd, m2r, pce;
    a_op = 2'd0; srcb = 2'd0; psrc = 2'd0;
    srca = 0; ad = 0; irw = 0; mw = 0; rw = 0; rd = 0; m2r = 0; pce = 0;
    case (s)
      0:     begin srcb = 2'd1; irw = 1; pce = 1; end
      1:     srcb = 2'd3;
      2, 9:  begin srca = 1; srcb = 2'd2; end
      3:     ad = 1;
      4:     begin m2r = 1; rw = 1; end
      5:     begin ad = 1; mw = 1; end
      6:     begin srca = 1; a_op = 2'd2; end
      7:     begin rd = 1; rw = 1; end
      8:     begin srca = 1; a_op = 2'd1; psrc = 2'd1; pce = z; end
      10:    rw = 1;
      11:    begin psrc = 2'd2; pce = 1; end
      default: ;
    endcase
    return {a_op, srca, srcb, psrc, ad, irw, mw, rw, rd, m2r, pce};
  endfunction

  // Step sequence of an instruction: fetch, decode, then its class-specific tail.
  task automatic build_seq(input logic [5:0] o);
    exp_q = {0, 1};
    case (o)
      OP_LW:    exp_q = {exp_q, 2, 3, 4};
      OP_SW:    exp_q = {exp_q, 2, 5};
      OP_RTYPE: exp_q = {exp_q, 6, 7};
      OP_BEQ:   exp_q = {exp_q, 8};
      OP_ADDI:  exp_q = {exp_q, 9, 10};
      OP_J:     exp_q = {exp_q, 11};
      default:  ;
    endcase
  endtask

  // Drive zero (random when zsel<0), then compare state and control word.
  task automatic sample(input int s, input string tag, input int zsel);
    if (zsel < 0) zero = 1'($urandom_range(0, 1));
    else          zero = 1'(zsel);
    #1;
    check($sformatf("%s_state_s%0d", tag, s), 16'(state), 16'(s));
    check($sformatf("%s_outs_s%0d", tag, s), 16'(outs), 16'(model_out(s, zero)));
  endtask

  // Entered and left on a falling edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] o, input int abort_at, input int zsel);
    string tag;
    tag = $sformatf("op%02h", o);
    build_seq(o);
    op = o;
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      sample(exp_q[i], tag, zsel);
      if (abort_at > 0 && abort_at == i) begin
        reset = 1'b1;
        @(negedge clk);
        sample(0, {tag, "_abort"}, -1);
        check({tag, "_abort_wr"}, 16'({regwrite, memwrite}), 16'd0);
        reset = 1'b0;
        return;
      end
    end
    @(negedge clk);
    sample(0, {tag, "_ret"}, -1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] o;
    int pick, abort_at;
    reset = 1'b1;
    op = OP_RTYPE;
    zero = 1'b0;
    @(negedge clk);
    sample(0, "reset", -1);
    reset = 1'b0;

    // Reset held two cycles while in EXECUTE.
    op = OP_RTYPE;
    sample(0, "exrst", -1);
    @(negedge clk); sample(1, "exrst", -1);
    @(negedge clk); sample(6, "exrst", -1);
    reset = 1'b1;
    @(negedge clk); sample(0, "exrst_r1", -1);
    check("exrst_regwrite", 16'(regwrite), 16'd0);
    @(negedge clk); sample(0, "exrst_r2", -1);
    reset = 1'b0;

    // Directed instruction classes, beq with both zero values.
    run_instr(OP_LW, 0, -1);
    run_instr(OP_SW, 0, -1);
    run_instr(OP_RTYPE, 0, -1);
    run_instr(OP_BEQ, 0, 1);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, -1);
    run_instr(6'h3F, 0, -1);
    run_instr(OP_ADDI, 0, -1);

    // op re-sampled in MEMADR: a non-memory op there returns to FETCH.
    op = OP_LW;
    sample(0, "madr", -1);
    @(negedge clk); sample(1, "madr", -1);
    @(negedge clk); sample(2, "madr", -1);
    op = OP_RTYPE;
    @(negedge clk); sample(0, "madr_ret", -1);

    // Random instruction stream with occasional mid-instruction reset.
    repeat (400) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: o = OP_LW;
        1: o = OP_SW;
        2: o = OP_RTYPE;
        3: o = OP_BEQ;
        4: o = OP_ADDI;
        5: o = OP_J;
        default: begin
          o = 6'($urandom_range(0, 63));
          while (o == OP_LW || o == OP_SW || o == OP_RTYPE || o == OP_BEQ ||
                 o == OP_ADDI || o == OP_J)
            o = 6'($urandom_range(0, 63));
        end
      endcase
      abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      run_instr(o, abort_at, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
